// File: rtl/sram_march_bist.sv
// March C- BIST controller for a single-port (1rw) OpenRAM macro wrapper.
// Drives the RW0_* port while running and stops at the first read mismatch.
module sram_march_bist #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 45,
  parameter int unsigned MASK_W = 1,
  parameter int unsigned DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask
);

  localparam logic [ADDR_W-1:0] LastRow = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        elem_q, elem_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic              phase_q, phase_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic              cmp_exp_q, cmp_exp_d;
  logic [2:0]        cmp_elem_q, cmp_elem_d;
  logic [ADDR_W-1:0] cmp_row_q, cmp_row_d;
  logic              fail_q, fail_d;
  logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]        fail_elem_q, fail_elem_d;

  logic op_write, wr_one, rd_one, descending, row_last_op, elem_last_row, mismatch;

  // Element decode: M0 = w0, M5 = r0, M1..M4 = read (phase 0) then write (phase 1).
  always_comb begin
    op_write = phase_q;
    unique case (elem_q)
      3'd0:    op_write = 1'b1;
      3'd5:    op_write = 1'b0;
      default: op_write = phase_q;
    endcase
    wr_one        = (elem_q == 3'd1) || (elem_q == 3'd3);
    rd_one        = (elem_q == 3'd2) || (elem_q == 3'd4);
    descending    = (elem_q >= 3'd3);
    row_last_op   = (elem_q == 3'd0) || (elem_q == 3'd5) || phase_q;
    elem_last_row = descending ? (row_q == '0) : (row_q == LastRow);
    mismatch      = cmp_valid_q && (RW0_rdata != {DATA_W{cmp_exp_q}});
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      elem_q      <= '0;
      row_q       <= '0;
      phase_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_elem_q  <= '0;
      cmp_row_q   <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      row_q       <= row_d;
      phase_q     <= phase_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_elem_q  <= cmp_elem_d;
      cmp_row_q   <= cmp_row_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    row_d       = row_q;
    phase_d     = phase_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    // A read issued this cycle is compared next cycle, unless we are already stopping.
    cmp_valid_d = (state_q == StRun) && !op_write && !mismatch;
    cmp_exp_d   = rd_one;
    cmp_elem_d  = elem_q;
    cmp_row_d   = row_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          elem_d      = '0;
          row_d       = '0;
          phase_d     = 1'b0;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_elem_d = '0;
        end
      end
      StRun: begin
        if (mismatch) begin
          state_d     = StDone;
          fail_d      = 1'b1;
          fail_addr_d = cmp_row_q;
          fail_elem_d = cmp_elem_q;
        end else if (!row_last_op) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!elem_last_row) begin
            row_d = descending ? (row_q - ADDR_W'(1)) : (row_q + ADDR_W'(1));
          end else if (elem_q == 3'd5) begin
            state_d = StDrain;
          end else begin
            elem_d = elem_q + 3'd1;
            // M3..M5 run descending, so they start from the top row.
            row_d  = (elem_q >= 3'd2) ? LastRow : '0;
          end
        end
      end
      StDrain: begin
        state_d = StDone;
        if (mismatch) begin
          fail_d      = 1'b1;
          fail_addr_d = cmp_row_q;
          fail_elem_d = cmp_elem_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StRun) || (state_q == StDrain);
    done      = (state_q == StDone);
    fail      = fail_q;
    fail_addr = fail_addr_q;
    fail_elem = fail_elem_q;
    RW0_en    = (state_q == StRun);
    RW0_wmode = RW0_en && op_write;
    RW0_addr  = RW0_en ? row_q : '0;
    RW0_wdata = {DATA_W{RW0_wmode && wr_one}};
    RW0_wmask = {MASK_W{RW0_en}};
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Directed bench for sram_march_bist: behavioural 1rw macro models with injectable faults,
// one DEPTH=8 controller (ADDR_W=3) and one DEPTH=27 controller (ADDR_W=5).
module tb_sram_march_bist;
  localparam int unsigned DW   = 45;
  localparam int unsigned AW8  = 3;
  localparam int unsigned D8   = 8;
  localparam int unsigned AW27 = 5;
  localparam int unsigned D27  = 27;

  logic clk = 1'b0;
  logic rst_n, start8, start27;

  logic           busy8, done8, fail8, en8, wmode8;
  logic [AW8-1:0] fail_addr8, addr8;
  logic [2:0]     fail_elem8;
  logic [DW-1:0]  wdata8, rdata8;
  logic [0:0]     wmask8;

  logic            busy27, done27, fail27, en27, wmode27;
  logic [AW27-1:0] fail_addr27, addr27;
  logic [2:0]      fail_elem27;
  logic [DW-1:0]   wdata27, rdata27;
  logic [0:0]      wmask27;

  logic [DW-1:0] mem8  [D8];
  logic [DW-1:0] mem27 [32];
  int fault_mode = 0;  // 0 none, 1 row5 bit7 SA1, 2 row0 bit0 SA0, 3 write row3 aliases row6

  int n_checks = 0;
  int n_fail   = 0;

  bit exp_w[$];
  int exp_a[$];
  bit exp_d[$];

  always #5 clk = ~clk;

  sram_march_bist #(.ADDR_W(AW8), .DATA_W(DW), .MASK_W(1), .DEPTH(D8)) dut8 (
    .clock(clk), .reset_n(rst_n), .start(start8), .busy(busy8), .done(done8), .fail(fail8),
    .fail_addr(fail_addr8), .fail_elem(fail_elem8), .RW0_addr(addr8), .RW0_wdata(wdata8),
    .RW0_rdata(rdata8), .RW0_en(en8), .RW0_wmode(wmode8), .RW0_wmask(wmask8)
  );

  sram_march_bist #(.ADDR_W(AW27), .DATA_W(DW), .MASK_W(1), .DEPTH(D27)) dut27 (
    .clock(clk), .reset_n(rst_n), .start(start27), .busy(busy27), .done(done27), .fail(fail27),
    .fail_addr(fail_addr27), .fail_elem(fail_elem27), .RW0_addr(addr27), .RW0_wdata(wdata27),
    .RW0_rdata(rdata27), .RW0_en(en27), .RW0_wmode(wmode27), .RW0_wmask(wmask27)
  );

  function automatic logic [DW-1:0] rd8(input logic [AW8-1:0] a);
    logic [DW-1:0] v;
    v = mem8[a];
    if (fault_mode == 1 && a == 3'd5) v[7] = 1'b1;
    if (fault_mode == 2 && a == 3'd0) v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (en8) begin
      if (wmode8) begin
        mem8[addr8] <= wdata8;
        if (fault_mode == 3 && addr8 == 3'd3) mem8[6] <= wdata8;
      end else begin
        rdata8 <= rd8(addr8);
      end
    end
    if (en27) begin
      if (wmode27) mem27[addr27] <= wdata27;
      else         rdata27 <= mem27[addr27];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic build_trace(input int d);
    int row;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < d; i++) begin
        row = (e < 3) ? i : d - 1 - i;
        if (e == 0) begin
          exp_w.push_back(1'b1); exp_a.push_back(row); exp_d.push_back(1'b0);
        end else begin
          exp_w.push_back(1'b0); exp_a.push_back(row); exp_d.push_back(1'b0);
          if (e < 5) begin
            exp_w.push_back(1'b1); exp_a.push_back(row); exp_d.push_back(e == 1 || e == 3);
          end
        end
      end
    end
  endtask

  task automatic chk_all_zero8(input string tag);
    chk({tag, "_busy"}, 64'(busy8), 64'd0);
    chk({tag, "_done"}, 64'(done8), 64'd0);
    chk({tag, "_fail"}, 64'(fail8), 64'd0);
    chk({tag, "_fail_addr"}, 64'(fail_addr8), 64'd0);
    chk({tag, "_fail_elem"}, 64'(fail_elem8), 64'd0);
    chk({tag, "_en"}, 64'(en8), 64'd0);
    chk({tag, "_wmode"}, 64'(wmode8), 64'd0);
    chk({tag, "_wmask"}, 64'(wmask8), 64'd0);
    chk({tag, "_addr"}, 64'(addr8), 64'd0);
    chk({tag, "_wdata"}, 64'(wdata8), 64'd0);
  endtask

  // Pulses start on the DEPTH=8 controller and follows the run until busy drops.
  task automatic run8(input bit trace, input int restart_at, input int reset_at,
                      input int exp_cycles, input string tag);
    int k;
    logic [DW-1:0] ev;
    k = 0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, "_start_clears_fail"}, 64'(fail8), 64'd0);
    chk({tag, "_start_clears_elem"}, 64'(fail_elem8), 64'd0);
    while (busy8 && k < 2000) begin
      if (k == reset_at) begin
        rst_n = 1'b0;
        #1;
        chk_all_zero8({tag, "_async_reset"});
        return;
      end
      if (trace) begin
        if (k < exp_w.size()) begin
          ev = {DW{exp_d[k]}};
          chk({tag, "_en"}, 64'(en8), 64'd1);
          chk({tag, "_wmode"}, 64'(wmode8), 64'(exp_w[k]));
          chk({tag, "_addr"}, 64'(addr8), 64'(exp_a[k]));
          chk({tag, "_wmask"}, 64'(wmask8), 64'd1);
          if (exp_w[k]) chk({tag, "_wdata"}, 64'(wdata8), 64'(ev));
        end else begin
          chk({tag, "_drain_en"}, 64'(en8), 64'd0);
        end
      end
      start8 = (k == restart_at);
      tick();
      k++;
    end
    start8 = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(k), 64'(exp_cycles));
    chk({tag, "_done"}, 64'(done8), 64'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n   = 1'b0;
    start8  = 1'b0;
    start27 = 1'b0;
    build_trace(D8);
    #12;
    chk_all_zero8("reset");
    chk("reset_busy27", 64'(busy27), 64'd0);
    chk("reset_en27", 64'(en27), 64'd0);
    rst_n = 1'b1;
    tick();

    // Fault-free pass with full trace check.
    run8(1'b1, -1, -1, 81, "pass");
    chk("pass_fail", 64'(fail8), 64'd0);
    chk("pass_fail_addr", 64'(fail_addr8), 64'd0);
    chk("pass_fail_elem", 64'(fail_elem8), 64'd0);

    // Start pulsed mid-run is ignored.
    run8(1'b0, 10, -1, 81, "restart_ignored");
    chk("restart_fail", 64'(fail8), 64'd0);

    // Row 5 bit 7 stuck-at-1: row 5 read at cycle 18, compared at 19.
    fault_mode = 1;
    run8(1'b0, -1, -1, 20, "sa1");
    chk("sa1_fail", 64'(fail8), 64'd1);
    chk("sa1_fail_addr", 64'(fail_addr8), 64'd5);
    chk("sa1_fail_elem", 64'(fail_elem8), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("sa1_no_en_after_done", 64'(en8), 64'd0);
      tick();
    end

    // Row 0 bit 0 stuck-at-0: first caught by the M2 r1 of row 0 (cycle 24).
    fault_mode = 2;
    run8(1'b0, -1, -1, 26, "sa0");
    chk("sa0_fail", 64'(fail8), 64'd1);
    chk("sa0_fail_addr", 64'(fail_addr8), 64'd0);
    chk("sa0_fail_elem", 64'(fail_elem8), 64'd2);

    // Write to row 3 also lands in row 6: M1 r0 of row 6 (cycle 20) sees ones.
    fault_mode = 3;
    run8(1'b0, -1, -1, 22, "alias");
    chk("alias_fail", 64'(fail8), 64'd1);
    chk("alias_fail_addr", 64'(fail_addr8), 64'd6);
    chk("alias_fail_elem", 64'(fail_elem8), 64'd1);

    // Reset in the middle of M3 (cycles 40..55), then a clean full pass.
    fault_mode = 0;
    run8(1'b1, -1, 45, 0, "mid_reset");
    #3;
    rst_n = 1'b1;
    tick();
    chk("post_reset_busy", 64'(busy8), 64'd0);
    chk("post_reset_done", 64'(done8), 64'd0);
    run8(1'b1, -1, -1, 81, "after_reset");
    chk("after_reset_fail", 64'(fail8), 64'd0);

    // DEPTH=27, non-power-of-2 row range.
    start27 = 1'b1;
    tick();
    start27 = 1'b0;
    k = 0;
    while (busy27 && k < 3000) begin
      if (en27) chk("d27_addr_in_range", 64'(addr27 <= 5'd26), 64'd1);
      if (k == 26)  chk("d27_m0_last", 64'(addr27), 64'd26);
      if (k == 27)  chk("d27_m1_start", 64'(addr27), 64'd0);
      if (k == 135) chk("d27_m3_start", 64'(addr27), 64'd26);
      if (k == 189) chk("d27_m4_start", 64'(addr27), 64'd26);
      if (k == 243) chk("d27_m5_start", 64'(addr27), 64'd26);
      if (k == 269) chk("d27_m5_last", 64'(addr27), 64'd0);
      if (k == 270) chk("d27_drain_en", 64'(en27), 64'd0);
      tick();
      k++;
    end
    chk("d27_busy_cycles", 64'(k), 64'd271);
    chk("d27_done", 64'(done27), 64'd1);
    chk("d27_fail", 64'(fail27), 64'd0);
    chk("d27_fail_elem", 64'(fail_elem27), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_march_bist.md
# sram_march_bist

Built-in self-test controller for one single-port (1rw) OpenRAM macro wrapper in the FreePDK45 flow. It is the initiator side of the `RW0_*` port: it drives address, write data, enable, write mode and write mask into the wrapper, checks `RW0_rdata` against expected values, and reports pass/fail. It runs a March C- sequence and stops at the first mismatch. It sits between the functional port mux and the `*_ext` wrapper, and is active only while running.

## Interface
- `ADDR_W`, default 9: address width; must match the wrapper.
- `DATA_W`, default 45: data width.
- `MASK_W`, default 1: write-mask width; driven all-ones.
- `DEPTH`, default 512: number of rows tested (0..DEPTH-1). Any value from 2 to 2^ADDR_W; non-power-of-2 is legal.
- `clock`  in  1  single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to start a test; honoured only in IDLE or DONE.
- `busy`  out  1  test in progress.
- `done`  out  1  test finished; held until the next accepted `start` or until reset.
- `fail`  out  1  valid when `done`=1; set if a mismatch was found.
- `fail_addr`  out  ADDR_W  row of the first mismatch; 0 if no mismatch.
- `fail_elem`  out  3  March element (1..5) of the first mismatch; 0 if no mismatch.
- `RW0_addr`  out  ADDR_W  macro address.
- `RW0_wdata`  out  DATA_W  write data: all-0 or all-1.
- `RW0_rdata`  in  DATA_W  read data, valid the cycle after the read cycle.
- `RW0_en`  out  1  macro enable; the wrapper inverts it to `csb0`.
- `RW0_wmode`  out  1  1 = write, 0 = read.
- `RW0_wmask`  out  MASK_W  all-ones whenever `RW0_en`=1, otherwise 0.

## Operation
March elements, applied in order:
- M0: ascending, w0.
- M1: ascending, r0 then w1.
- M2: ascending, r1 then w0.
- M3: descending, r0 then w1.
- M4: descending, r1 then w0.
- M5: descending, r0.

Definitions:
- Ascending means rows 0 to DEPTH-1; descending means DEPTH-1 to 0.
- "0" means all-zeros data and "1" means all-ones data.

States:
- IDLE → RUN on `start`.
- RUN → DRAIN after the last operation of M5.
- DRAIN → DONE.
- RUN or DRAIN → DONE early on a mismatch.
- DONE → RUN on `start`.

Counters:
- Element counter, 3 bits.
- Row counter, ADDR_W bits; counts up or down according to the element.
- Phase bit selects read or write within M1–M4.
- At the end of an element, the row counter loads the start row of the next element: 0 for ascending, DEPTH-1 for descending.
- The counter must never step outside 0..DEPTH-1.

Compare pipeline:
- Each read cycle registers the expected value, element and row.
- The next cycle compares `RW0_rdata` against the expected value, using the full width.
- The final M5 read is compared in DRAIN.

On the first mismatch:
- Capture `fail_addr` and `fail_elem` from the pipeline register.
- Set `fail`, go to DONE, and stop issuing operations.
- An operation issued in the same cycle as the comparison still completes; this is allowed.

Accepting `start` from DONE clears `fail`, `fail_addr` and `fail_elem`. `start` during RUN or DRAIN is ignored.

## Timing
- Reset, asynchronous, state IDLE:
  - `busy`, `done`, `fail`, `fail_addr`, `fail_elem` are all 0.
  - `RW0_en`, `RW0_wmode`, `RW0_wmask`, `RW0_addr`, `RW0_wdata` are all 0.
- If reset asserts mid-run, `RW0_en` drops immediately and the sequence aborts. Macro contents are undefined afterwards.
- `start` is sampled at edge T. From cycle T+1, `busy`=1 and the first M0 write is driven.
- One macro operation per cycle with no gaps:
  - M0: DEPTH cycles.
  - M1–M4: 2·DEPTH cycles each, read then write per row.
  - M5: DEPTH cycles.
  - Then 1 DRAIN cycle with `RW0_en`=0.
- `busy` stays high for exactly 10·DEPTH+1 cycles on a pass. On the next edge `busy`=0 and `done`=1.
- A mismatch is detected in cycle C. At edge C+1: `busy`=0, `done`=1, `fail`=1, and `RW0_en`=0 from then on.
- `RW0_rdata` is assumed to be valid one cycle after the read, which matches OpenRAM's synchronous read.

## Test plan
- Fault-free behavioural 1rw model, DEPTH=8, pulse `start`:
  - `busy` lasts 81 cycles.
  - Then `done`=1, `fail`=0, `fail_addr`=0, `fail_elem`=0.
  - The operation trace matches the March C- order exactly.
- Bit 7 of row 5 stuck-at-1, DEPTH=8 → `fail`=1, `fail_addr`=5, `fail_elem`=1; no `RW0_en` after `done`.
- Bit 0 of row 0 stuck-at-0 → `fail`=1, `fail_addr`=0, `fail_elem`=2.
- Address alias where a write to row 3 also writes row 6, DEPTH=8 → `fail`=1, `fail_addr`=6, `fail_elem`=1.
- DEPTH=27, ADDR_W=5, fault-free:
  - `busy` lasts 271 cycles.
  - `RW0_addr` never exceeds 26.
  - Descending elements start at 26.
  - `fail`=0.
- Control robustness:
  - `start` pulsed mid-RUN is ignored and the cycle count is unchanged.
  - `reset_n` low mid-M3 makes all outputs 0 immediately.
  - `start` after reset runs a full 81-cycle pass.
  - `start` from DONE with `fail`=1 clears `fail` on the next edge.
